pwm_reg_commit_ctrl: RTL
========================

# pwm_reg_commit_ctrl

Write-scheduling controller between the SPI register-write port and the PWM/output-enable register set. It buffers accepted register writes in a small FIFO and applies them to the active registers only at a PWM period boundary, so enable and duty changes never glitch mid-period. It sits between the SPI peripheral and the PWM peripheral inside the top-level user project.

## Interface
- `FIFO_DEPTH`, default 4: write-buffer entries; power of two, ≥2.
- `MAX_ADDR`, default 4: highest valid register address.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `wr_valid` in 1: write request from the SPI peripheral.
- `wr_ready` out 1: space available; equals !full; 0 while `rst` is high.
- `wr_addr` in 7: register address.
- `wr_data` in 8: register data.
- `period_end` in 1: one-cycle pulse from the PWM counter on wrap.
- `en_reg_out_7_0` out 8: active register, address 0x00.
- `en_reg_out_15_8` out 8: active register, address 0x01.
- `en_reg_pwm_7_0` out 8: active register, address 0x02.
- `en_reg_pwm_15_8` out 8: active register, address 0x03.
- `pwm_duty_cycle` out 8: active register, address 0x04.
- `pending` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `commit_pulse` out 1: one-cycle pulse after a commit batch completes.
- `drop_pulse` out 1: one-cycle pulse when an out-of-range write is discarded.

## Operation
- **Accept:** a write is accepted on an edge where `wr_valid && wr_ready`. If `wr_addr` ≤ `MAX_ADDR`, the write is pushed as {addr, data}. Otherwise nothing is pushed and `drop_pulse` is high for the next cycle.
- **State machine:** IDLE, ARMED, DRAIN.
  - IDLE → ARMED when the FIFO becomes non-empty.
  - ARMED → DRAIN on an edge sampling `period_end`=1. On entry, `batch` is latched as the current occupancy.
  - DRAIN pops one entry per cycle and writes it to its active register, exactly `batch` entries. On completion it goes to ARMED if the FIFO is non-empty, otherwise to IDLE. `commit_pulse` fires on this exit.
- **Ordering:** entries apply in FIFO order. Multiple writes to one address in a batch: the last one wins.
- **During DRAIN:** pushes are still accepted. They join the next batch, never the current one. `period_end` is ignored.
- In IDLE, `period_end` is ignored.
- **Simultaneous push and pop:** allowed. `pending` is unchanged in that case.
- **Full FIFO:** `wr_ready` is 0 even if a pop occurs in the same cycle. There is no combinational path from pop to ready.
- **Arithmetic:** FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. `pending` is 0..FIFO_DEPTH.

## Timing
- **Reset values:** all active registers 0x00, FIFO empty, `pending`=0, state IDLE, `commit_pulse`=0, `drop_pulse`=0, `wr_ready`=0.
- Reset asserted mid-DRAIN aborts the batch. Registers already applied return to 0 and the FIFO is flushed.
- **Push timing:** a push on edge N is visible in `pending` after N.
- **Same-edge push and period_end:** if a push into an empty FIFO and `period_end` occur on the same edge, the push does not commit. It waits for the next `period_end`.
- **Commit latency:** with `period_end` sampled in ARMED at edge M, entry i (1..k) is applied at edge M+i. `commit_pulse` is high in the cycle after edge M+k.
- **Single-write latency:** ≤ one PWM period + 2 cycles.

## Configuration
- `PWM_COMMIT_BYPASS_EN` defined:
  - FIFO and FSM are not built.
  - `wr_ready` is 1 when out of reset.
  - Valid writes apply to the active register at the acceptance edge.
  - `commit_pulse` pulses in the following cycle.
  - `pending` is 0.
  - `period_end` is ignored.
  - `drop_pulse` behaviour is unchanged.
- Undefined: buffered, period-aligned behaviour as above. This is the default.

## Test plan
- **Reset and single write:** reset, then write 0x04←0x80 with no `period_end` for 50 cycles. Expected: `pwm_duty_cycle` stays 0x00 and `pending`=1. Pulse `period_end`: duty becomes 0x80 one edge later, `commit_pulse` fires once, `pending`=0.
- **Fill and order:** write 0x00←0xAA, 0x00←0x55, 0x02←0x0F, 0x03←0xF0. Expected: `wr_ready`=0 and `pending`=4. After `period_end`: `en_reg_out_7_0`=0x55, `en_reg_pwm_7_0`=0x0F, `en_reg_pwm_15_8`=0xF0, applied over 4 consecutive edges.
- **Out-of-range address:** write 0x05←0xFF. Expected: `drop_pulse` one cycle, `pending` stays 0, all outputs unchanged.
- **Writes during DRAIN:** 3 entries are draining and 0x01←0x33 is pushed during the drain. Expected: 0x01 stays unchanged after `commit_pulse`, state returns to ARMED, and the next `period_end` applies 0x33.
- **Reset mid-operation:** assert `rst` during the second pop of a 4-entry batch. Expected: all outputs 0x00 immediately, `pending`=0, `wr_ready`=0 until release.
- **Bypass build:** with `PWM_COMMIT_BYPASS_EN`, write 0x04←0x40. Expected: duty=0x40 after the acceptance edge with no `period_end` needed.

Source files
------------

// File: rtl/pwm_reg_commit_ctrl.sv
// Buffers SPI register writes and applies them to the PWM/enable registers only at period boundaries.
// Build option: define PWM_COMMIT_BYPASS_EN for the unbuffered variant (writes apply at acceptance).
module pwm_reg_commit_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_ADDR   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [6:0]                  wr_addr,
   input  logic [7:0]                  wr_data,
   input  logic                        period_end,
   output logic [7:0]                  en_reg_out_7_0,
   output logic [7:0]                  en_reg_out_15_8,
   output logic [7:0]                  en_reg_pwm_7_0,
   output logic [7:0]                  en_reg_pwm_15_8,
   output logic [7:0]                  pwm_duty_cycle,
   output logic [$clog2(FIFO_DEPTH):0] pending,
   output logic                        commit_pulse,
   output logic                        drop_pulse
);

   localparam int         PW         = $clog2(FIFO_DEPTH);
   localparam int         CW         = PW + 1;
   localparam logic [6:0] MAX_ADDR_C = 7'(MAX_ADDR);

   logic       accept_s;
   logic       in_range_s;
   logic       push_s;
   logic       apply_s;
   logic [6:0] apply_addr_s;
   logic [7:0] apply_data_s;

   logic       ready_r;
   logic       commit_r;
   logic       drop_r;
   logic [7:0] out_lo_r;
   logic [7:0] out_hi_r;
   logic [7:0] pwm_lo_r;
   logic [7:0] pwm_hi_r;
   logic [7:0] duty_r;

   assign accept_s   = wr_valid & ready_r;
   assign in_range_s = (wr_addr <= MAX_ADDR_C);
   assign push_s     = accept_s & in_range_s;

   assign wr_ready        = ready_r;
   assign commit_pulse    = commit_r;
   assign drop_pulse      = drop_r;
   assign en_reg_out_7_0  = out_lo_r;
   assign en_reg_out_15_8 = out_hi_r;
   assign en_reg_pwm_7_0  = pwm_lo_r;
   assign en_reg_pwm_15_8 = pwm_hi_r;
   assign pwm_duty_cycle  = duty_r;

   // Out-of-range writes are consumed but never stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_r <= 1'b0;
      end else begin
         drop_r <= accept_s & ~in_range_s;
      end
   end

   // Active register set, written by whichever path feeds apply_s.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_lo_r <= 8'h00;
         out_hi_r <= 8'h00;
         pwm_lo_r <= 8'h00;
         pwm_hi_r <= 8'h00;
         duty_r   <= 8'h00;
      end else if (apply_s) begin
         case (apply_addr_s)
            7'd0:    out_lo_r <= apply_data_s;
            7'd1:    out_hi_r <= apply_data_s;
            7'd2:    pwm_lo_r <= apply_data_s;
            7'd3:    pwm_hi_r <= apply_data_s;
            7'd4:    duty_r   <= apply_data_s;
            default: duty_r   <= duty_r;
         endcase
      end else begin
         duty_r <= duty_r;
      end
   end

`ifdef PWM_COMMIT_BYPASS_EN

   logic unused_s;
   assign unused_s = period_end;

   assign apply_s      = push_s;
   assign apply_addr_s = wr_addr;
   assign apply_data_s = wr_data;
   assign pending      = '0;

   // Always ready once out of reset; commit flag follows each applied write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_r  <= 1'b0;
         commit_r <= 1'b0;
      end else begin
         ready_r  <= 1'b1;
         commit_r <= push_s;
      end
   end

`else

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] ZERO_C  = CW'(0);
   localparam logic [PW-1:0] PONE_C  = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state_r;
   logic [14:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;
   logic [CW-1:0] batch_r;
   logic          pop_s;

   assign pop_s        = (state_r == S_DRAIN) && (cnt_r != ZERO_C);
   assign apply_s      = pop_s;
   assign apply_addr_s = mem_r[rd_ptr_r][14:8];
   assign apply_data_s = mem_r[rd_ptr_r][7:0];
   assign pending      = cnt_r;

   // Occupancy after this edge; feeds the registered ready so pop never reaches wr_ready combinationally.
   always_comb begin
      cnt_next_s = cnt_r;
      if (push_s && !pop_s) begin
         cnt_next_s = cnt_r + ONE_C;
      end else if (pop_s && !push_s) begin
         cnt_next_s = cnt_r - ONE_C;
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {wr_addr, wr_data};
      end
   end

   // FIFO pointers, occupancy and ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         ready_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PONE_C;
         end
         cnt_r   <= cnt_next_s;
         ready_r <= (cnt_next_s != DEPTH_C);
      end
   end

   // Commit scheduler: batch size is frozen on entry so writes arriving mid-drain wait for the next period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= S_IDLE;
         batch_r  <= '0;
         commit_r <= 1'b0;
      end else begin
         commit_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if ((cnt_r != ZERO_C) || push_s) begin
                  state_r <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (period_end && (cnt_r != ZERO_C)) begin
                  batch_r <= cnt_r;
                  state_r <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (batch_r <= ONE_C) begin
                  batch_r  <= '0;
                  commit_r <= 1'b1;
                  state_r  <= (cnt_next_s != ZERO_C) ? S_ARMED : S_IDLE;
               end else begin
                  batch_r <= batch_r - ONE_C;
               end
            end
            default: begin
               state_r <= S_IDLE;
               batch_r <= '0;
            end
         endcase
      end
   end

`endif

endmodule
